// File: rtl/sqrt_engine.sv
// Integer square root engine: digit-by-digit floor(sqrt(a)) with remainder.
// The subtractions go through a shared external adder with a req/ack handshake,
// so the engine only compares and shifts locally.
module sqrt_engine #(
  parameter int WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_bi,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH/2-1:0] y_bo,
  output logic [WIDTH/2:0]   rem_bo,
  output logic               adder_req_o,
  input  logic               adder_ack_i,
  output logic [WIDTH-1:0]   adder_inp1_bo,
  output logic [WIDTH-1:0]   adder_inp2_bo,
  input  logic [WIDTH-1:0]   adder_out_bi
);

  localparam int HW = WIDTH / 2;

  // Odd or out-of-range widths break the two-bits-per-step walk of m.
  if ((WIDTH % 2) != 0 || WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("sqrt_engine: WIDTH must be even and within 4..32");
  end

  // m starts at the highest even bit position of the radicand.
  localparam logic [WIDTH-1:0] M_INIT = {2'b01, {(WIDTH-2){1'b0}}};

  typedef enum logic [1:0] {IDLE, CMP, SUB} state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] x_q, x_n;
  logic [WIDTH-1:0] res_q, res_n;
  logic [WIDTH-1:0] m_q, m_n;
  logic             req_q, req_n;
  logic [WIDTH-1:0] op1_q, op1_n;
  logic [WIDTH-1:0] op2_q, op2_n;
  logic [HW-1:0]    y_q, y_n;
  logic [HW:0]      rem_q, rem_n;
  logic             done_q, done_n;

  // res and m never share set bits, so OR is the sum; x < 2^WIDTH always holds.
  logic [WIDTH-1:0] b;
  logic             x_ge_b;
  assign b      = res_q | m_q;
  assign x_ge_b = (x_q >= b);

  // Register all state; reset wins over start and ack in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      x_q     <= '0;
      res_q   <= '0;
      m_q     <= '0;
      req_q   <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      y_q     <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      x_q     <= x_n;
      res_q   <= res_n;
      m_q     <= m_n;
      req_q   <= req_n;
      op1_q   <= op1_n;
      op2_q   <= op2_n;
      y_q     <= y_n;
      rem_q   <= rem_n;
      done_q  <= done_n;
    end
  end

  // Next-state: one compare/shift per CMP cycle, subtraction outsourced in SUB.
  always_comb begin
    state_n = state_q;
    x_n     = x_q;
    res_n   = res_q;
    m_n     = m_q;
    req_n   = req_q;
    op1_n   = op1_q;
    op2_n   = op2_q;
    y_n     = y_q;
    rem_n   = rem_q;
    done_n  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          x_n     = a_bi;
          res_n   = '0;
          m_n     = M_INIT;
          state_n = CMP;
        end
      end
      CMP: begin
        if (m_q == '0) begin
          y_n     = res_q[HW-1:0];
          rem_n   = x_q[HW:0];
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (x_ge_b) begin
          res_n   = (res_q >> 1) | m_q;
          m_n     = m_q >> 2;
          op1_n   = x_q;
          op2_n   = ~b + WIDTH'(1);
          req_n   = 1'b1;
          state_n = SUB;
        end else begin
          res_n   = res_q >> 1;
          m_n     = m_q >> 2;
        end
      end
      SUB: begin
        if (adder_ack_i) begin
          x_n     = adder_out_bi;
          req_n   = 1'b0;
          op1_n   = '0;
          op2_n   = '0;
          state_n = CMP;
        end
      end
      default: begin
        req_n   = 1'b0;
        op1_n   = '0;
        op2_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign y_bo          = y_q;
  assign rem_bo        = rem_q;
  assign adder_req_o   = req_q;
  assign adder_inp1_bo = op1_q;
  assign adder_inp2_bo = op2_q;

endmodule
